// File: rtl/int_ctrl.sv
// int_ctrl: prioritized interrupt controller with memory-mapped enable/pending
// registers, a vectored request/acknowledge handshake and an in-service mask.
// Channel 0 has the highest priority.
// Optional feature: define INT_NESTING_EN to let a higher-priority channel
// preempt the channel currently in service.
module int_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter logic [15:0] VEC_STRIDE = 16'h0010,
  parameter logic [15:0] EN_ADDR    = 16'hC002,
  parameter logic [15:0] PEND_ADDR  = 16'hC003
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [15:0]        addr,
  input  logic [15:0]        wdata,
  input  logic               we,
  input  logic               re,
  output logic [15:0]        rdata,
  output logic               int_req,
  output logic [15:0]        int_vec,
  input  logic               int_ack,
  input  logic               rti,
  output logic [NUM_IRQ-1:0] int_active
);

`ifdef INT_NESTING_EN
  localparam logic NESTING = 1'b1;
`else
  localparam logic NESTING = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, hist_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] enable_q, enable_d;
  logic [NUM_IRQ-1:0] active_q, active_d;
  logic [NUM_IRQ-1:0] sel_oh_q, sel_oh_d;
  logic               int_req_q, int_req_d;
  logic [15:0]        vec_q, vec_d;
  logic [15:0]        rdata_q, rdata_d;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] ack_oh;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] active_after_rti;
  logic               raise;
  logic               unused_wdata;

  // Only the low NUM_IRQ bits of wdata carry register content.
  assign unused_wdata = ^wdata;

  // Isolate the lowest set bit as a one-hot mask.
  function automatic logic [NUM_IRQ-1:0] low_oh(input logic [NUM_IRQ-1:0] v);
    return v & ((~v) + NUM_IRQ'(1));
  endfunction

  // Index of the lowest set bit (0 when v is zero).
  function automatic logic [2:0] low_idx(input logic [NUM_IRQ-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (v[NUM_IRQ-1-i]) idx = 3'(NUM_IRQ-1-i);
    end
    return idx;
  endfunction

  // Synchronizers, edge history and all architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      active_q  <= '0;
      sel_oh_q  <= '0;
      int_req_q <= 1'b0;
      vec_q     <= '0;
      rdata_q   <= '0;
      state_q   <= IDLE;
    end else begin
      sync1_q   <= irq_in;
      sync2_q   <= sync1_q;
      hist_q    <= sync2_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      active_q  <= active_d;
      sel_oh_q  <= sel_oh_d;
      int_req_q <= int_req_d;
      vec_q     <= vec_d;
      rdata_q   <= rdata_d;
      state_q   <= state_d;
    end
  end

  // Register file: pending set/clear, enable load, read data capture, in-service mask.
  always_comb begin
    rise    = sync2_q & ~hist_q;
    cand    = pending_q & enable_q;
    ack_oh  = (state_q == REQ && int_ack) ? sel_oh_q : '0;
    w1c     = (we && addr == PEND_ADDR) ? wdata[NUM_IRQ-1:0] : '0;
    // A rising edge wins over both software clear and acknowledge clear.
    pending_d = (pending_q & ~w1c & ~ack_oh) | rise;
    enable_d  = (we && addr == EN_ADDR) ? wdata[NUM_IRQ-1:0] : enable_q;
    // rti with nothing in service leaves the mask at zero.
    active_after_rti = rti ? (active_q & (active_q - NUM_IRQ'(1))) : active_q;
    active_d         = active_after_rti | ack_oh;
    rdata_d = rdata_q;
    if (re) begin
      if (addr == EN_ADDR)        rdata_d = 16'(enable_q);
      else if (addr == PEND_ADDR) rdata_d = 16'(pending_q);
      else                        rdata_d = '0;
    end
  end

  // Request FSM: next state, latched selection and vector.
  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    sel_oh_d  = sel_oh_q;
    vec_d     = vec_q;
    raise     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand != '0) raise = 1'b1;
      end
      REQ: begin
        if (int_ack) begin
          state_d   = SERVICE;
          int_req_d = 1'b0;
        end
      end
      SERVICE: begin
        // Preemption compares against the mask as it stood before this cycle's rti.
        if (NESTING && ((cand & (low_oh(active_q) - NUM_IRQ'(1))) != '0)) raise = 1'b1;
        else if (active_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (raise) begin
      state_d   = REQ;
      int_req_d = 1'b1;
      sel_oh_d  = low_oh(cand);
      vec_d     = VEC_BASE + 16'(low_idx(cand)) * VEC_STRIDE;
    end
  end

  assign rdata      = rdata_q;
  assign int_req    = int_req_q;
  assign int_vec    = vec_q;
  assign int_active = active_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a behavioural model of the interrupt controller.
module tb_int_ctrl;

  localparam logic [15:0] EN   = 16'hC002;
  localparam logic [15:0] PEND = 16'hC003;
  localparam int          VB   = 16;
  localparam int          VS   = 16;
`ifdef INT_NESTING_EN
  localparam logic NEST = 1'b1;
`else
  localparam logic NEST = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  irq_in;
  logic [15:0] addr, wdata;
  logic        we, re;
  logic [15:0] rdata;
  logic        int_req;
  logic [15:0] int_vec;
  logic        int_ack, rti;
  logic [3:0]  int_active;

  int checks = 0;
  int errors = 0;

  int_ctrl #(
    .NUM_IRQ(4), .VEC_BASE(16'h0010), .VEC_STRIDE(16'h0010),
    .EN_ADDR(16'hC002), .PEND_ADDR(16'hC003)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .int_req(int_req), .int_vec(int_vec),
    .int_ack(int_ack), .rti(rti), .int_active(int_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0]  m_p0, m_p1, m_p2;   // irq_in as seen 1, 2, 3 edges ago
  logic [3:0]  m_pend, m_en, m_act;
  logic        m_req;
  int          m_sel;
  logic [15:0] m_vec, m_rdata;
  logic [3:0]  cand, ack_bits, w1c_bits;
  logic        raise;

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 4;
  endfunction

  assign cand     = m_pend & m_en;
  assign ack_bits = (m_req && int_ack) ? 4'(1 << m_sel) : 4'b0;
  assign w1c_bits = (we && addr == PEND) ? wdata[3:0] : 4'b0;
  assign raise    = !m_req && (cand != 0) &&
                    ((m_act == 0) || (NEST && (lowest(cand) < lowest(m_act))));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p0 <= 0; m_p1 <= 0; m_p2 <= 0;
      m_pend <= 0; m_en <= 0; m_act <= 0;
      m_req <= 0; m_sel <= 0; m_vec <= 0; m_rdata <= 0;
    end else begin
      m_p0 <= irq_in; m_p1 <= m_p0; m_p2 <= m_p1;
      m_pend <= (m_pend & ~w1c_bits & ~ack_bits) | (m_p1 & ~m_p2);
      if (we && addr == EN) m_en <= wdata[3:0];
      m_act <= ((rti && m_act != 0) ? (m_act & 4'(m_act - 1)) : m_act) | ack_bits;
      if (raise) begin
        m_req <= 1'b1;
        m_sel <= lowest(cand);
        m_vec <= 16'(VB + lowest(cand) * VS);
      end else if (m_req && int_ack) begin
        m_req <= 1'b0;
      end
      if (re) m_rdata <= (addr == EN) ? {12'h0, m_en} : (addr == PEND) ? {12'h0, m_pend} : 16'h0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always begin
    @(posedge clk);
    #1;
    chk("cyc_int_req", {15'h0, int_req}, {15'h0, m_req});
    chk("cyc_int_active", {12'h0, int_active}, {12'h0, m_act});
    chk("cyc_rdata", rdata, m_rdata);
    if (m_req) chk("cyc_int_vec", int_vec, m_vec);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    step(1);
    we = 1'b0; addr = 16'h0; wdata = 16'h0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    addr = a; re = 1'b1;
    step(1);
    re = 1'b0; addr = 16'h0;
    chk(name, rdata, exp);
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(1); int_ack = 1'b0;
  endtask

  task automatic pulse_rti();
    rti = 1'b1; step(1); rti = 1'b0;
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom_range(0, 3))
      0, 1:    return EN;
      2:       return PEND;
      default: return 16'($urandom);
    endcase
  endfunction

  int r;

  initial begin
    rst_n = 1'b0; irq_in = 0; addr = 0; wdata = 0; we = 0; re = 0; int_ack = 0; rti = 0;
    step(2);
    chk("reset_int_req", {15'h0, int_req}, 16'h0);
    chk("reset_int_vec", int_vec, 16'h0);
    chk("reset_int_active", {12'h0, int_active}, 16'h0);
    chk("reset_rdata", rdata, 16'h0);
    rst_n = 1'b1;
    step(1);

    // Single channel: pending after 3 edges, request one edge later.
    wr(EN, 16'h000F);
    irq_in = 4'b0100;
    step(3);
    chk("s33_no_req_yet", {15'h0, int_req}, 16'h0);
    rd(PEND, 16'h0004, "s33_pending");
    chk("s33_int_req", {15'h0, int_req}, 16'h1);
    chk("s33_int_vec", int_vec, 16'h0030);
    chk("s33_model_vec", m_vec, 16'h0030);
    irq_in = 0;
    pulse_ack();
    chk("s33_active", {12'h0, int_active}, 16'h0004);
    chk("s33_req_drop", {15'h0, int_req}, 16'h0);
    rd(PEND, 16'h0000, "s33_pending_clr");
    pulse_rti();
    chk("s33_active_clr", {12'h0, int_active}, 16'h0);

    // Two channels together: lower index first.
    irq_in = 4'b1010;
    step(4);
    chk("s34_vec1", int_vec, 16'h0020);
    chk("s34_req1", {15'h0, int_req}, 16'h1);
    irq_in = 0;
    pulse_ack();
    step(2);
    chk("s34_no_req_in_service", {15'h0, int_req}, 16'h0);
    pulse_rti();
    chk("s34_active_zero", {12'h0, int_active}, 16'h0);
    step(1);
    chk("s34_req2", {15'h0, int_req}, 16'h1);
    chk("s34_vec2", int_vec, 16'h0040);
    pulse_ack();
    pulse_rti();

    // Disabled channel waits for enable.
    wr(EN, 16'h0000);
    irq_in = 4'b0001;
    step(3);
    irq_in = 0;
    step(3);
    chk("s35_masked", {15'h0, int_req}, 16'h0);
    wr(EN, 16'h0001);
    step(1);
    chk("s35_req", {15'h0, int_req}, 16'h1);
    chk("s35_vec", int_vec, 16'h0010);
    pulse_ack();
    pulse_rti();

    // Higher-priority channel arrives while channel 2 is in service.
    wr(EN, 16'h000F);
    irq_in = 4'b0100;
    step(4);
    chk("s36_vec2", int_vec, 16'h0030);
    pulse_ack();
    irq_in = 4'b0001;
    step(4);
    irq_in = 0;
`ifdef INT_NESTING_EN
    chk("s36_preempt_req", {15'h0, int_req}, 16'h1);
    chk("s36_preempt_vec", int_vec, 16'h0010);
    pulse_ack();
    chk("s36_nested_active", {12'h0, int_active}, 16'h0005);
    pulse_rti();
    chk("s36_after_rti1", {12'h0, int_active}, 16'h0004);
    pulse_rti();
    chk("s36_after_rti2", {12'h0, int_active}, 16'h0000);
    step(1);
    chk("s36_idle", {15'h0, int_req}, 16'h0);
`else
    chk("s36_no_preempt", {15'h0, int_req}, 16'h0);
    step(2);
    chk("s36_still_none", {15'h0, int_req}, 16'h0);
    pulse_rti();
    chk("s36_active_zero", {12'h0, int_active}, 16'h0);
    step(1);
    chk("s36_req_after_rti", {15'h0, int_req}, 16'h1);
    chk("s36_vec_after_rti", int_vec, 16'h0010);
    pulse_ack();
    pulse_rti();
`endif

    // Clear racing a rising edge: set wins; level alone does not re-set.
    wr(EN, 16'h0000);
    irq_in = 4'b0100;
    step(2);
    wr(PEND, 16'h0004);
    rd(PEND, 16'h0004, "s38_set_wins");
    wr(PEND, 16'h0004);
    rd(PEND, 16'h0000, "s38_level_no_reset");
    irq_in = 0;

    // Reset asserted while a request is outstanding.
    wr(EN, 16'h000F);
    irq_in = 4'b0010;
    step(4);
    chk("s37_req", {15'h0, int_req}, 16'h1);
    irq_in = 0;
    rd(EN, 16'h000F, "s37_rd_en");
    #2 rst_n = 1'b0;
    #1;
    chk("s37_rst_req", {15'h0, int_req}, 16'h0);
    chk("s37_rst_rdata", rdata, 16'h0);
    chk("s37_rst_vec", int_vec, 16'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    rd(EN, 16'h0000, "s37_en_after");
    rd(PEND, 16'h0000, "s37_pend_after");

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      we = 0; re = 0; int_ack = 0; rti = 0; addr = 0; wdata = 0;
      if ($urandom_range(0, 5) == 0) irq_in = irq_in ^ 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        we = 1; addr = pick_addr(); wdata = 16'($urandom);
      end else if (r < 4) begin
        re = 1; addr = pick_addr();
      end
      if (m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0)) int_ack = 1;
      if ($urandom_range(0, 4) == 0) rti = 1;
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step(1);
    end

    we = 0; re = 0; int_ack = 0; rti = 0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
